// File: rtl/jtag_pkg.sv
// jtag_pkg: shared TAP state encoding and default instruction opcodes.
// States use the conventional 1149.1 encoding so tap_state matches common debug tooling.
package jtag_pkg;
    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    localparam int         IR_LENGTH_DEFAULT = 4;
    localparam logic [3:0] BYPASS            = 4'b1111;
    localparam logic [3:0] USER              = 4'b0010;
endpackage

// File: rtl/tap_fsm.sv
// tap_fsm: 16-state 1149.1 TAP state register, advanced by TMS on each TCK rising edge.
module tap_fsm
    import jtag_pkg::*;
(
    input  logic       i_tck,
    input  logic       i_trst,
    input  logic       i_tms,
    output tap_state_e o_state
);
    tap_state_e r_state;

    always_ff @(posedge i_tck or posedge i_trst) begin
        if (i_trst) begin
            r_state <= TEST_LOGIC_RESET;
        end else begin
            case (r_state)
                TEST_LOGIC_RESET: r_state <= i_tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
                RUN_TEST_IDLE:    r_state <= i_tms ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_DR:        r_state <= i_tms ? SELECT_IR : CAPTURE_DR;
                CAPTURE_DR:       r_state <= i_tms ? EXIT1_DR  : SHIFT_DR;
                SHIFT_DR:         r_state <= i_tms ? EXIT1_DR  : SHIFT_DR;
                EXIT1_DR:         r_state <= i_tms ? UPDATE_DR : PAUSE_DR;
                PAUSE_DR:         r_state <= i_tms ? EXIT2_DR  : PAUSE_DR;
                EXIT2_DR:         r_state <= i_tms ? UPDATE_DR : SHIFT_DR;
                UPDATE_DR:        r_state <= i_tms ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_IR:        r_state <= i_tms ? TEST_LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:       r_state <= i_tms ? EXIT1_IR  : SHIFT_IR;
                SHIFT_IR:         r_state <= i_tms ? EXIT1_IR  : SHIFT_IR;
                EXIT1_IR:         r_state <= i_tms ? UPDATE_IR : PAUSE_IR;
                PAUSE_IR:         r_state <= i_tms ? EXIT2_IR  : PAUSE_IR;
                EXIT2_IR:         r_state <= i_tms ? UPDATE_IR : SHIFT_IR;
                UPDATE_IR:        r_state <= i_tms ? SELECT_DR : RUN_TEST_IDLE;
                default:          r_state <= TEST_LOGIC_RESET;
            endcase
        end
    end

    assign o_state = r_state;
endmodule

// File: rtl/tap_controller.sv
// tap_controller: 1149.1 TAP with instruction register, DR strobes and bypass/user select decode.
// Strobes and TDO are Moore decodes of the state register so they cannot glitch on TMS.
module tap_controller
    import jtag_pkg::*;
#(
    parameter int                   IR_LENGTH   = IR_LENGTH_DEFAULT,
    parameter logic [IR_LENGTH-1:0] USER_OPCODE = IR_LENGTH'(USER)
) (
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       SO_DR_IN,
    output logic       Capture_DR,
    output logic       Shift_DR,
    output logic       Update_DR,
    output logic       tdr_Select,
    output logic       user_Select,
    output logic       TDO,
    output logic       TDO_EN,
    output logic [3:0] tap_state
);
    tap_state_e           w_state;
    logic [IR_LENGTH-1:0] r_ir_shift;
    logic [IR_LENGTH-1:0] r_ir_reg;

    tap_fsm u_fsm (
        .i_tck   (TCK),
        .i_trst  (TRST),
        .i_tms   (TMS),
        .o_state (w_state)
    );

    // ir_reg only moves at UPDATE_IR, so selects stay stable through shift and pause
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_ir_shift <= '0;
            r_ir_reg   <= '1;
        end else begin
            if (w_state == CAPTURE_IR)
                r_ir_shift <= IR_LENGTH'(1);
            else if (w_state == SHIFT_IR)
                r_ir_shift <= {r_ir_shift[IR_LENGTH-2:0], TDI};
            if (w_state == TEST_LOGIC_RESET)
                r_ir_reg <= '1;
            else if (w_state == UPDATE_IR)
                r_ir_reg <= r_ir_shift;
        end
    end

    assign Capture_DR  = w_state == CAPTURE_DR;
    assign Shift_DR    = w_state == SHIFT_DR;
    assign Update_DR   = w_state == UPDATE_DR;
    assign TDO_EN      = w_state == SHIFT_IR || w_state == SHIFT_DR;
    assign user_Select = r_ir_reg == USER_OPCODE;
    assign tdr_Select  = !user_Select;
    assign TDO         = w_state == SHIFT_IR ? r_ir_shift[IR_LENGTH-1] :
                         w_state == SHIFT_DR ? SO_DR_IN : 1'b0;
    assign tap_state   = w_state;
endmodule

// File: tb/tb_tap_controller.sv
// tb_tap_controller: directed TAP walk with hand-computed expectations checked by immediate assertions.
module tb_tap_controller;
    import jtag_pkg::*;

    logic       TCK = 1'b0, TRST = 1'b1, TMS = 1'b1, TDI = 1'b0, SO_DR_IN = 1'b0;
    logic       Capture_DR, Shift_DR, Update_DR, tdr_Select, user_Select, TDO, TDO_EN;
    logic [3:0] tap_state;
    int         checks = 0, failures = 0;

    tap_controller dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .SO_DR_IN(SO_DR_IN),
        .Capture_DR(Capture_DR), .Shift_DR(Shift_DR), .Update_DR(Update_DR),
        .tdr_Select(tdr_Select), .user_Select(user_Select),
        .TDO(TDO), .TDO_EN(TDO_EN), .tap_state(tap_state)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    initial begin
        logic       ir_tdi [4];
        logic       ir_tms [4];
        logic       ir_tdo [4];
        logic       p_tms  [8];
        tap_state_e p_st   [8];

        repeat (2) @(posedge TCK);
        #1;
        chk("rst_state", tap_state, TEST_LOGIC_RESET);
        chk("rst_tdr", tdr_Select, 1);
        chk("rst_user", user_Select, 0);
        chk("rst_strobes", {Capture_DR, Shift_DR, Update_DR}, 0);
        chk("rst_tdo", {TDO, TDO_EN}, 0);
        TRST = 1'b0;
        step(0, 0);
        chk("to_rti", tap_state, RUN_TEST_IDLE);

        repeat (5) step(1, 0);
        chk("five_ones_tlr", tap_state, TEST_LOGIC_RESET);
        chk("five_ones_tdr", tdr_Select, 1);

        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        chk("shift_ir_state", tap_state, SHIFT_IR);
        chk("shift_ir_en", TDO_EN, 1);
        ir_tdi = '{0, 0, 1, 0};
        ir_tms = '{0, 0, 0, 1};
        ir_tdo = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ir_tdo%0d", i), TDO, ir_tdo[i]);
            chk($sformatf("ir_hold_user%0d", i), user_Select, 0);
            step(ir_tms[i], ir_tdi[i]);
        end
        chk("exit1_ir", tap_state, EXIT1_IR);
        chk("ir_shift_val", dut.r_ir_shift, 4'b0010);
        chk("exit1_ir_user", user_Select, 0);
        step(1, 0);
        chk("update_ir", tap_state, UPDATE_IR);
        chk("update_ir_user", user_Select, 0);
        step(0, 0);
        chk("user_sel", user_Select, 1);
        chk("user_tdr", tdr_Select, 0);

        step(1, 0); step(0, 0);
        chk("cap_dr_state", tap_state, CAPTURE_DR);
        chk("cap_dr_hi", {Capture_DR, Shift_DR}, 2'b10);
        step(0, 0);
        chk("cap_dr_one_cycle", {Capture_DR, Shift_DR}, 2'b01);
        for (int i = 0; i < 4; i++) begin
            logic so;
            so = (i % 2) == 0;
            SO_DR_IN = so;
            #1;
            chk($sformatf("dr_tdo%0d", i), TDO, so);
            chk($sformatf("dr_shift%0d", i), {Shift_DR, TDO_EN}, 2'b11);
            step(0, 0);
        end
        SO_DR_IN = 1'b1;
        step(1, 0);
        chk("exit1_dr_tdo", {TDO, TDO_EN, Shift_DR}, 0);
        step(1, 0);
        chk("update_dr", Update_DR, 1);
        step(0, 0);
        chk("update_dr_off", Update_DR, 0);
        SO_DR_IN = 1'b0;

        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        ir_tdi = '{0, 1, 1, 1};
        for (int i = 0; i < 4; i++) step(ir_tms[i], ir_tdi[i]);
        step(1, 0); step(0, 0);
        chk("op7_ir", dut.r_ir_reg, 4'b0111);
        chk("op7_tdr", tdr_Select, 1);
        chk("op7_user", user_Select, 0);

        p_tms = '{1, 0, 0, 1, 0, 0, 1, 0};
        p_st  = '{SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, PAUSE_DR, EXIT2_DR, SHIFT_DR};
        for (int i = 0; i < 8; i++) begin
            step(p_tms[i], 0);
            chk($sformatf("pause_st%0d", i), tap_state, p_st[i]);
            chk($sformatf("pause_upd%0d", i), Update_DR, 0);
        end
        step(1, 0); step(1, 0);
        chk("pause_update", {tap_state, Update_DR}, {UPDATE_DR, 1'b1});
        step(0, 0);

        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(0, 1);
        chk("pre_trst", tap_state, SHIFT_IR);
        #2;
        TRST = 1'b1;
        #1;
        chk("trst_state", tap_state, TEST_LOGIC_RESET);
        chk("trst_ir", dut.r_ir_reg, 4'b1111);
        chk("trst_ir_shift", dut.r_ir_shift, 4'b0000);
        chk("trst_tdr", tdr_Select, 1);
        chk("trst_tdo", {TDO, TDO_EN}, 0);
        step(0, 1);
        chk("trst_hold", tap_state, TEST_LOGIC_RESET);
        TRST = 1'b0;

        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        chk("deep_shift", tap_state, SHIFT_IR);
        repeat (5) step(1, 0);
        chk("deep_to_tlr", tap_state, TEST_LOGIC_RESET);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
